// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART transmit path.
//   ST_*             FSM state encodings for the transmit arbiter
//   UART_FRAME_TICKS enabled ticks per UART frame (idle, start, 8 data, stop)
//   UART_BYTE_W      transmitted byte width
package uart_pkg;
  localparam int UART_BYTE_W      = 8;
  localparam int UART_FRAME_TICKS = 11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  typedef logic [UART_BYTE_W-1:0] byte_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   i_req   request vector
//   i_last  index of the most recent winner; the search starts at i_last+1
//   o_oh    one-hot winner (all zero when no request)
//   o_idx   index of the winner (0 when no request)
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_oh,
  output logic [IW-1:0]      o_idx
);
  logic w_found;
  int   w_i;

  // Walk last+1 .. last+NUM_REQ (mod NUM_REQ); the previous winner is
  // visited last, so it cannot win again while anyone else is pending.
  always_comb begin
    o_oh    = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_i     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_i = (int'(i_last) + k) % NUM_REQ;
      if (!w_found && i_req[IW'(w_i)]) begin
        w_found          = 1'b1;
        o_oh[IW'(w_i)]   = 1'b1;
        o_idx            = IW'(w_i);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART byte transmitter
// among NUM_REQ requesters, all in the baud_clk domain.
//   baud_clk     bit-rate clock, rising edge
//   rst          asynchronous active-high reset (shared with the transmitter)
//   i_req        level request per requester
//   i_req_data   byte of requester i on [8i+7:8i]
//   o_gnt        one-hot pulse in the IDLE tick where the request is taken;
//                i_req_data is captured on the edge ending that tick
//   o_done       one-hot pulse on the last enabled tick of the owner's frame
//   o_busy       high from grant through end of gap
//   o_tx_din     byte to transmitter, changes only on a grant edge
//   o_tx_en      transmitter enable (low = load buffer, high = shift)
//   i_tx_ready   transmitter ready flag (watchdog build only)
//   o_err        frame watchdog failure pulse (watchdog build only)
// Optional feature: define UART_TX_ARB_WATCHDOG_EN to enable the tx_ready
// watchdog; otherwise o_err is tied 0 and i_tx_ready is ignored.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int FRAME_TICKS = UART_FRAME_TICKS,
  parameter int GAP_TICKS   = 1
) (
  input  logic                           baud_clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]             o_gnt,
  output logic [NUM_REQ-1:0]             o_done,
  output logic                           o_busy,
  output logic [UART_BYTE_W-1:0]         o_tx_din,
  output logic                           o_tx_en,
  input  logic                           i_tx_ready,
  output logic                           o_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FRAME_TICKS + GAP_TICKS);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [IW-1:0]      r_last;
  byte_t              r_tx_din;

  logic [NUM_REQ-1:0] w_pick_oh;
  logic [IW-1:0]      w_pick_idx;
  byte_t              w_pick_byte;
  logic               w_grant;
  logic               w_last_tick;
  logic               w_gap_end;
  logic               w_wd_fail;
  logic               w_send_end;
  logic [NUM_REQ-1:0] w_owner_oh;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .i_req  (i_req),
    .i_last (r_last),
    .o_oh   (w_pick_oh),
    .o_idx  (w_pick_idx)
  );

  always_comb begin
    w_pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_pick_oh[i]) w_pick_byte = i_req_data[i*UART_BYTE_W +: UART_BYTE_W];
  end

  // The grant is decided in the IDLE tick itself so that a request held
  // across a frame boundary is picked up without an extra idle tick.
  assign w_grant     = (r_state == ST_IDLE) && (|i_req);
  assign w_last_tick = (r_state == ST_SEND) && (r_cnt == CW'(FRAME_TICKS-1));
  assign w_gap_end   = (r_state == ST_GAP)  && (r_cnt == CW'(GAP_TICKS-1));
  assign w_send_end  = w_last_tick || w_wd_fail;
  // r_last doubles as the owner of the frame in flight.
  assign w_owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_last;

`ifdef UART_TX_ARB_WATCHDOG_EN
  logic r_seen_low;

  // tx_ready must have gone low by the 2nd enabled tick (buffer taken) and
  // be high again on the last enabled tick (frame shifted out).
  assign w_wd_fail = (r_state == ST_SEND) &&
                     (((r_cnt == CW'(1)) && i_tx_ready && !r_seen_low) ||
                      ((r_cnt == CW'(FRAME_TICKS-1)) && !i_tx_ready));

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst)                       r_seen_low <= 1'b0;
    else if (r_state == ST_LOAD)   r_seen_low <= 1'b0;
    else if (r_state == ST_SEND && !i_tx_ready) r_seen_low <= 1'b1;
  end
`else
  logic w_unused_ready;
  assign w_unused_ready = i_tx_ready;
  assign w_wd_fail      = 1'b0;
`endif

  assign o_gnt    = w_grant ? w_pick_oh : '0;
  assign o_done   = ((r_state == ST_SEND) && w_send_end) ? w_owner_oh : '0;
  assign o_busy   = (r_state != ST_IDLE) || w_grant;
  assign o_tx_din = r_tx_din;
  // A watchdog failure drops the enable in the failing tick itself.
  assign o_tx_en  = (r_state == ST_SEND) && !w_wd_fail;
  assign o_err    = w_wd_fail;

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_last   <= IW'(NUM_REQ-1);
      r_tx_din <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_grant) begin
            r_state  <= ST_LOAD;
            r_last   <= w_pick_idx;
            r_tx_din <= w_pick_byte;
          end
        end
        ST_LOAD: begin
          r_state <= ST_SEND;
          r_cnt   <= '0;
        end
        ST_SEND: begin
          if (w_send_end) begin
            r_state <= ST_GAP;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (w_gap_end) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a grant
// scoreboard (expected owner/byte pushed when requests are driven, popped
// when a grant appears). Define UART_TX_ARB_WATCHDOG_EN to add the
// watchdog step.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           baud_clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   gnt, done;
  logic           busy, tx_en, tx_ready, err;
  logic [7:0]     tx_din;

  logic           force_hi = 1'b0;
  int             en_cnt = 0;

  typedef struct { int idx; logic [7:0] b; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int tick_no = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .FRAME_TICKS(11), .GAP_TICKS(1)) dut (
    .baud_clk   (baud_clk),
    .rst        (rst),
    .i_req      (req),
    .i_req_data (req_data),
    .o_gnt      (gnt),
    .o_done     (done),
    .o_busy     (busy),
    .o_tx_din   (tx_din),
    .o_tx_en    (tx_en),
    .i_tx_ready (tx_ready),
    .o_err      (err)
  );

  always #5 baud_clk = ~baud_clk;

  // Transmitter ready model: low while shifting, high on the last enabled
  // tick; force_hi models a stuck-high ready.
  always @(posedge baud_clk) en_cnt <= tx_en ? en_cnt + 1 : 0;
  assign tx_ready = force_hi || (en_cnt == 10);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge baud_clk);
    #1;
    tick_no++;
  endtask

  task automatic push(input int idx, input logic [7:0] b);
    exp_t e;
    e.idx = idx;
    e.b   = b;
    exp_q.push_back(e);
  endtask

  // Called in the grant tick; returns in the tick after the gap.
  task automatic run_frame(input int idx, input logic [7:0] b, input bit drop, input bit scramble);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    check("grant_gnt", gnt, oh);
    check("grant_busy", busy, 1);
    check("grant_txen", tx_en, 0);
    step();
    if (drop) req[idx] = 1'b0;
    if (scramble) req_data[8*idx +: 8] = ~b;
    #1;
    check("load_txen", tx_en, 0);
    check("load_din", tx_din, b);
    check("load_gnt", gnt, 0);
    for (int k = 0; k < 11; k++) begin
      step();
      check("send_txen", tx_en, 1);
      check("send_din", tx_din, b);
      check("send_busy", busy, 1);
      check("send_done", done, (k == 10) ? oh : '0);
    end
    step();
    check("gap_txen", tx_en, 0);
    check("gap_busy", busy, 1);
    check("gap_done", done, 0);
    step();
  endtask

  task automatic wait_gnt(input bit drop, input bit scramble, output int gtick);
    exp_t e;
    int   n;
    n = 0;
    gtick = -1;
    #1;
    while (gnt == '0 && n < 40) begin
      step();
      n++;
    end
    if (gnt == '0) begin
      checks++;
      failures++;
      $error("FAIL gnt_timeout observed=0 expected=grant");
    end else if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty observed=%0h expected=none", gnt);
    end else begin
      e = exp_q.pop_front();
      gtick = tick_no;
      run_frame(e.idx, e.b, drop, scramble);
    end
  endtask

  initial begin
    int g, prev;
    // Reset state
    #1 rst = 1'b1;
    step();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_din", tx_din, 0);
    check("rst_txen", tx_en, 0);
    check("rst_err", err, 0);
    step();
    rst = 1'b0;
    step();
    check("idle_busy", busy, 0);

    // Single request: A5 from requester 0
    tick_no = 1;
    req = 4'b0001;
    req_data[7:0] = 8'hA5;
    push(0, 8'hA5);
    wait_gnt(1, 0, g);
    check("single_gtick", g, 1);
    check("single_idle_busy", busy, 0);
    check("single_idle_gnt", gnt, 0);

    // All four held after a fresh reset: 0,1,2,3,0 spaced 14 ticks
    rst = 1'b1;
    #1 rst = 1'b0;
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req = 4'b1111;
    push(0, 8'h10); push(1, 8'h21); push(2, 8'h32); push(3, 8'h43); push(0, 8'h10);
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(0, 0, g);
      if (i > 0) check("rr_spacing", g - prev, 14);
      prev = g;
    end
    req = '0;
    #1;
    check("rr_release_gnt", gnt, 0);
    step();
    check("rr_release_busy", busy, 0);

    // Fairness: bring last to 2, then 0101 -> 0 then 2; data changed after gnt
    req = 4'b0010; req_data[15:8] = 8'h5A; push(1, 8'h5A); wait_gnt(1, 0, g);
    req = 4'b0100; req_data[23:16] = 8'hC3; push(2, 8'hC3); wait_gnt(1, 0, g);
    req_data[7:0] = 8'h77; req_data[23:16] = 8'h88;
    req = 4'b0101;
    push(0, 8'h77); push(2, 8'h88);
    wait_gnt(1, 1, g);
    wait_gnt(1, 1, g);
    check("fair_din_hold", tx_din, 8'h88);

    // Reset mid-frame at enabled tick 5
    req = 4'b0001; req_data[7:0] = 8'h66;
    #1;
    check("mid_gnt", gnt, 4'b0001);
    step();
    req = '0;
    for (int k = 0; k < 5; k++) step();
    check("mid_txen_before", tx_en, 1);
    rst = 1'b1;
    #1;
    check("mid_txen", tx_en, 0);
    check("mid_busy", busy, 0);
    check("mid_gnt0", gnt, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check("mid_no_done", done, 0);
    end
    // last is back at 3: 1001 goes to 0 first, then 3
    req_data[7:0] = 8'h3C; req_data[31:24] = 8'hE1;
    req = 4'b1001;
    push(0, 8'h3C); push(3, 8'hE1);
    wait_gnt(1, 0, g);
    wait_gnt(1, 0, g);

`ifdef UART_TX_ARB_WATCHDOG_EN
    // Watchdog: ready stuck high -> err on 2nd enabled tick
    force_hi = 1'b1;
    req = 4'b0010; req_data[15:8] = 8'h99;
    #1;
    check("wd_gnt", gnt, 4'b0010);
    step();
    req = '0;
    #1;
    check("wd_load_txen", tx_en, 0);
    step();
    check("wd_t1_txen", tx_en, 1);
    check("wd_t1_err", err, 0);
    step();
    check("wd_t2_err", err, 1);
    check("wd_t2_done", done, 4'b0010);
    check("wd_t2_txen", tx_en, 0);
    step();
    check("wd_gap_txen", tx_en, 0);
    check("wd_gap_err", err, 0);
    check("wd_gap_busy", busy, 1);
    step();
    check("wd_idle_busy", busy, 0);
    force_hi = 1'b0;
    req_data[7:0] = 8'hB0; req_data[23:16] = 8'hB2;
    req = 4'b0101;
    push(2, 8'hB2); push(0, 8'hB0);
    wait_gnt(1, 0, g);
    wait_gnt(1, 0, g);
`endif

    check("sb_drained", exp_q.size(), 0);
    check("final_err", err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
